// File: rtl/mux_scan.sv
// mux_scan: NCH-channel valid/ready multiplexer with fixed-select and
// round-robin scan modes, feeding a single-entry registered output stage.
module mux_scan #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned NCH   = 4,
   parameter int unsigned SELW  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_ch,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam int unsigned LAST_CH = NCH - 1;

   logic [SELW-1:0]  ptr;
   logic             grant_valid;
   logic [SELW-1:0]  grant_idx;
   logic [WIDTH-1:0] grant_word;
   logic             load;

   // Arbitration: fixed select, or first valid channel searching from ptr
   always_comb begin
      int unsigned j;
      grant_valid = 1'b0;
      grant_idx   = '0;
      j           = 0;
      if (!mode) begin
         // sel values at or beyond NCH match no channel and so never grant
         for (int unsigned i = 0; i < NCH; i++) begin
            if (SELW'(i) == sel && in_valid[i]) begin
               grant_valid = 1'b1;
               grant_idx   = SELW'(i);
            end
         end
      end else begin
         for (int unsigned k = 0; k < NCH; k++) begin
            j = (32'(ptr) + k) % NCH;
            if (!grant_valid && in_valid[j]) begin
               grant_valid = 1'b1;
               grant_idx   = SELW'(j);
            end
         end
      end
   end

   // Word carried by the granted channel
   always_comb begin
      grant_word = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         if (SELW'(i) == grant_idx) begin
            grant_word = in_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign load = (!out_valid || out_ready) && grant_valid;

   // One-hot handshake back to the granted channel; held low during reset
   always_comb begin
      in_ready = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         in_ready[i] = rst_n && load && (grant_idx == SELW'(i));
      end
   end

   // Round-robin pointer advances past the winner only on a scan-mode load
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (load && mode) begin
         ptr <= (grant_idx == SELW'(LAST_CH)) ? '0 : grant_idx + SELW'(1);
      end
   end

   // Single-entry output register: load, drain, or hold under backpressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
      end else if (load) begin
         out_valid <= 1'b1;
         out_data  <= grant_word;
         out_ch    <= grant_idx;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/mux_scan.md
MUX_SCAN -- requirements
Module: mux_scan

Interface
REQ-001 The module SHALL have parameter WIDTH, default 1, meaning data bits per channel.
REQ-002 The module SHALL have parameter NCH, default 4, meaning number of input channels (2..16).
REQ-003 The module SHALL have parameter SELW, default 2, meaning select/channel-index width, with 2**SELW >= NCH.
REQ-004 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 Port in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port in_valid  input  NCH  channel i offers a word.
REQ-008 Port in_ready  output  NCH  channel i's word is taken this cycle.
REQ-009 Port mode  input  1  0 = fixed select, 1 = round-robin scan.
REQ-010 Port sel  input  SELW  channel index used in fixed mode.
REQ-011 Port out_data  output  WIDTH  registered selected word.
REQ-012 Port out_ch  output  SELW  index of the channel that supplied out_data.
REQ-013 Port out_valid  output  1  out_data/out_ch hold a word.
REQ-014 Port out_ready  input  1  downstream accepts the word this cycle.

Function
REQ-015 Output stage SHALL be a single-entry register; load enable: load = (!out_valid || out_ready) && grant_valid.
REQ-016 Fixed mode SHALL grant channel sel when sel < NCH and in_valid[sel] = 1; otherwise no grant.
REQ-017 Fixed mode with sel >= NCH SHALL never grant, drive in_ready = 0, and raise no error.
REQ-018 Round-robin mode SHALL grant the first channel with in_valid = 1, searching ptr, ptr+1, ... modulo NCH.
REQ-019 On each round-robin load, ptr SHALL become (granted index + 1) modulo NCH, wrapping NCH-1 -> 0.
REQ-020 ptr SHALL change only on a round-robin load; fixed-mode traffic SHALL leave ptr unchanged.
REQ-021 in_ready SHALL be combinational and one-hot-or-zero.
REQ-022 in_ready[i] SHALL be 1 exactly when load = 1 and i is the granted channel; no input-to-output combinational path on out_data.
REQ-023 On load, the register SHALL capture out_data = granted word, out_ch = granted index, out_valid = 1 at the next edge; latency is 1 cycle.
REQ-024 When out_valid = 1 and out_ready = 1 with no grant, out_valid SHALL clear to 0 at the next edge; out_data and out_ch hold their last values.
REQ-025 Simultaneous drain and load (out_valid = 1, out_ready = 1, grant) SHALL replace the word with no bubble, sustaining one word per cycle.
REQ-026 While out_valid = 1 and out_ready = 0, out_data, out_ch and out_valid SHALL stay stable, and all in_ready SHALL be 0.
REQ-027 mode and sel SHALL be sampled every cycle; a change affects only the next grant, never a held word.
REQ-028 Switching mode from 1 to 0 and back SHALL resume round-robin from the retained ptr.

Reset
REQ-029 While rst_n = 0, outputs SHALL immediately be out_valid = 0, out_data = 0, out_ch = 0, all in_ready = 0, and ptr SHALL be 0, regardless of clk.
REQ-030 Reset asserted while a word is held SHALL discard that word.
REQ-031 First grant after rst_n rises SHALL occur no earlier than the first rising edge with rst_n = 1.

Verification (NCH=4, WIDTH=8)
REQ-032 Fixed mode, sel=2, in_valid=4'b0100, in_data ch2=8'hA5, out_ready=1 -> in_ready=4'b0100 same cycle; next cycle out_data=8'hA5, out_ch=2, out_valid=1.
REQ-033 Round-robin, all in_valid=1, out_ready=1 for 6 cycles from reset -> out_ch sequence 0,1,2,3,0,1 on consecutive cycles, no bubbles.
REQ-034 Backpressure: word held, out_ready=0 for 3 cycles while in_valid=4'b1111 -> in_ready=0 and outputs stable for 3 cycles; the word drains on the cycle out_ready=1.
REQ-035 Round-robin, ptr=3, in_valid=4'b0011 -> ch0 granted and ptr becomes 1; the next grant is ch1.
REQ-036 Fixed mode, sel=3 with NCH=3 (parameter override) and in_valid=3'b111 -> no grant ever, out_valid stays 0.
REQ-037 rst_n pulled low mid-cycle with out_valid=1 -> out_valid=0 and out_data=0 immediately, without a clock edge; after release, round-robin restarts at ch0.
